// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared widths and ALU operation encoding for the reg_alu datapath
package reg_alu_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;
    typedef enum logic [2:0] {
        OP_ZERO  = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_PASSA = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_INC   = 3'b111
    } alu_op_t;
endpackage

// File: rtl/reg_alu_if.sv
// reg_alu_if: register-file addressing, ALU select and result bundle
interface reg_alu_if
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();
    logic              rf_w_en;
    logic [ADDR_W-1:0] rf_w_addr;
    logic [ADDR_W-1:0] rf_ra_addr;
    logic [ADDR_W-1:0] rf_rb_addr;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] q;
    modport master (output rf_w_en, rf_w_addr, rf_ra_addr, rf_rb_addr, alu_sel, input q);
    modport slave (input rf_w_en, rf_w_addr, rf_ra_addr, rf_rb_addr, alu_sel, output q);
endinterface

// File: rtl/reg_file.sv
// reg_file: register array with async clear, one sync write port, two comb read ports
module reg_file
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    // storage: reset clears every entry (index 0 included), otherwise one write per enabled edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end
    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];
endmodule

// File: rtl/reg_alu.sv
// reg_alu: register file feeding a combinational ALU whose result is written back
module reg_alu
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic       clk,
    input logic       reset_n,
    reg_alu_if.slave  bus
);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] y;
    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .w_en    (bus.rf_w_en),
        .w_addr  (bus.rf_w_addr),
        .w_data  (y),
        .ra_addr (bus.rf_ra_addr),
        .rb_addr (bus.rf_rb_addr),
        .ra_data (a),
        .rb_data (b)
    );
    // ALU: modulo-2**DATA_W arithmetic, carries dropped; storage breaks the write-back loop
    always_comb begin
        y = '0;
        case (alu_op_t'(bus.alu_sel))
            OP_ZERO:  y = '0;
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_PASSA: y = a;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_INC:   y = a + 1'b1;
            default:  y = '0;
        endcase
    end
    assign bus.q = y;
endmodule

// File: tb/tb_reg_alu.sv
// tb_reg_alu: directed self-checking bench for reg_alu
module tb_reg_alu;
    logic clk = 1'b0;
    logic reset_n;
    int checks = 0;
    int errors = 0;

    reg_alu_if #(.DATA_W(16), .ADDR_W(5)) bus ();

    reg_alu #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] exp);
        checks++;
        assert (bus.q === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, bus.q, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [4:0] r, input logic [15:0] exp);
        bus.rf_w_en    = 1'b0;
        bus.alu_sel    = 3'b011;
        bus.rf_ra_addr = r;
        #1;
        chk(tag, exp);
    endtask

    task automatic op(input string tag, input logic [2:0] sel, input logic [4:0] ra,
                      input logic [4:0] rb, input logic [15:0] exp);
        bus.rf_w_en    = 1'b0;
        bus.alu_sel    = sel;
        bus.rf_ra_addr = ra;
        bus.rf_rb_addr = rb;
        #1;
        chk(tag, exp);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [4:0] wa, input int n);
        @(negedge clk);
        bus.alu_sel    = sel;
        bus.rf_ra_addr = ra;
        bus.rf_rb_addr = rb;
        bus.rf_w_addr  = wa;
        bus.rf_w_en    = 1'b1;
        edges(n);
        bus.rf_w_en    = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.rf_w_en    = 1'b0;
        bus.rf_w_addr  = 5'd0;
        bus.rf_ra_addr = 5'd5;
        bus.rf_rb_addr = 5'd9;
        bus.alu_sel    = 3'b001;
        #1;
        chk("reset_add", 16'h0000);
        bus.alu_sel   = 3'b111;
        bus.rf_w_en   = 1'b1;
        bus.rf_w_addr = 5'd5;
        #1;
        chk("reset_inc", 16'h0001);
        edges(2);
        chk("reset_no_write", 16'h0001);
        reset_n     = 1'b1;
        bus.rf_w_en = 1'b0;
        for (int i = 0; i < 32; i++) rd($sformatf("zero_r%0d", i), i[4:0], 16'h0000);

        wr(3'b111, 5'd1, 5'd0, 5'd1, 3);
        rd("inc3_r1", 5'd1, 16'h0003);
        @(negedge clk);
        bus.alu_sel    = 3'b111;
        bus.rf_ra_addr = 5'd1;
        bus.rf_w_addr  = 5'd1;
        bus.rf_w_en    = 1'b0;
        edges(2);
        rd("hold_r1", 5'd1, 16'h0003);

        wr(3'b111, 5'd2, 5'd0, 5'd2, 1);
        rd("inc1_r2", 5'd2, 16'h0001);
        op("add", 3'b001, 5'd1, 5'd2, 16'h0004);
        op("sub_wrap", 3'b010, 5'd2, 5'd1, 16'hFFFE);
        wr(3'b010, 5'd2, 5'd1, 5'd3, 1);
        rd("wr_r3", 5'd3, 16'hFFFE);
        wr(3'b111, 5'd3, 5'd0, 5'd3, 1);
        rd("inc_r3_ffff", 5'd3, 16'hFFFF);
        wr(3'b111, 5'd3, 5'd0, 5'd3, 1);
        rd("inc_r3_wrap", 5'd3, 16'h0000);

        @(negedge clk);
        op("and", 3'b100, 5'd1, 5'd2, 16'h0001);
        op("or", 3'b101, 5'd1, 5'd2, 16'h0003);
        op("xor", 3'b110, 5'd1, 5'd2, 16'h0002);
        op("pass", 3'b011, 5'd1, 5'd2, 16'h0003);
        op("zero", 3'b000, 5'd1, 5'd2, 16'h0000);

        wr(3'b001, 5'd1, 5'd2, 5'd4, 1);
        rd("seed_r4", 5'd4, 16'h0004);
        @(negedge clk);
        bus.alu_sel    = 3'b111;
        bus.rf_ra_addr = 5'd4;
        bus.rf_rb_addr = 5'd4;
        bus.rf_w_addr  = 5'd4;
        bus.rf_w_en    = 1'b1;
        #1;
        chk("rdw_before", 16'h0005);
        @(posedge clk);
        #1;
        bus.rf_w_en = 1'b0;
        chk("rdw_after", 16'h0006);
        rd("rdw_r4", 5'd4, 16'h0005);

        @(negedge clk);
        bus.alu_sel    = 3'b111;
        bus.rf_ra_addr = 5'd1;
        bus.rf_w_addr  = 5'd1;
        bus.rf_w_en    = 1'b1;
        reset_n        = 1'b0;
        #1;
        chk("async_clear", 16'h0001);
        edges(1);
        chk("reset_blocks_write", 16'h0001);
        reset_n = 1'b1;
        rd("post_reset_r1", 5'd1, 16'h0000);
        rd("post_reset_r4", 5'd4, 16'h0000);
        wr(3'b111, 5'd1, 5'd0, 5'd1, 1);
        rd("first_write", 5'd1, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
